multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
//  Sequences the shared PC/ALU/memory datapath over 3-5 cycles per instruction.
//  Stalls on a memory ready handshake and counts retired instructions.
//  Sits between instruction register (op) and datapath; ALUOp feeds the existing aludec.
// PARAMETERS
//  WAIT_MEM  1   1: honour MemReady; 0: treat MemReady as constant 1
//  CNT_W     32  width of InstrCount retired-instruction counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  op         in   7      opcode of instruction register
//  Zero       in   1      ALU zero flag
//  MemReady   in   1      memory access completes this cycle
//  PCWrite    out  1      PC register enable
//  AdrSrc     out  1      0: address=PC, 1: address=ALUOut
//  MemWrite   out  1      data memory write strobe
//  IRWrite    out  1      capture instruction and OldPC
//  ResultSrc  out  2      00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out  2      00 PC, 01 OldPC, 10 rs1
//  ALUSrcB    out  2      00 rs2, 01 ImmExt, 10 const 4
//  ImmSrc     out  2      immediate format, combinational from op
//  ALUOp      out  2      00 add, 01 sub (branch), 10 funct-decoded
//  RegWrite   out  1      register file write enable
//  IllegalOp  out  1      1-cycle pulse: unsupported opcode in DECODE
//  Retire     out  1      1-cycle pulse: last cycle of an instruction
//  InstrCount out  CNT_W  retired-instruction count; wraps to 0
// BEHAVIOUR
//  Reset: state=FETCH, InstrCount=0; PCWrite/IRWrite/MemWrite/RegWrite/IllegalOp/Retire forced 0
//   while reset_n low. Reset mid-instruction abandons it; first clock after release is a FETCH cycle.
//  rdy = MemReady | ~WAIT_MEM. Outputs not listed per state are 0.
//  ImmSrc: lw/I-type 00, sw 01, beq 10, jal 11, other 00 (independent of state).
//  PCWrite = PCUpdate | (Branch & Zero).
//  FETCH   : AdrSrc0, SrcA00, SrcB10, ALUOp00, Res10, IRWrite=PCUpdate=rdy; rdy ? DECODE : FETCH
//  DECODE  : SrcA01, SrcB01, ALUOp00. op 0000011/0100011 -> MEMADR; 0110011 -> EXECR;
//            0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; other -> FETCH, IllegalOp=1
//  MEMADR  : SrcA10, SrcB01, ALUOp00; lw -> MEMREAD, sw -> MEMWR
//  MEMREAD : Res00, AdrSrc1; rdy ? MEMWB : MEMREAD
//  MEMWB   : Res01, RegWrite, Retire -> FETCH
//  MEMWR   : Res00, AdrSrc1, MemWrite held until rdy; rdy -> FETCH with Retire
//  EXECR   : SrcA10, SrcB00, ALUOp10 -> ALUWB
//  EXECI   : SrcA10, SrcB01, ALUOp10 -> ALUWB
//  ALUWB   : Res00, RegWrite, Retire -> FETCH
//  BEQ     : SrcA10, SrcB00, ALUOp01, Res00, Branch, Retire -> FETCH
//  JAL     : SrcA01, SrcB10, ALUOp00, Res00, PCUpdate -> ALUWB
//  Latency (rdy=1): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles. Each wait cycle adds 1.
//  InstrCount += 1 on every Retire cycle, modulo 2^CNT_W; IllegalOp does not retire.
//  op sampled only in DECODE and MEMADR; op changes elsewhere are ignored.
// TESTING
//  Reset, MemReady=1, op=lw: FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite & Retire only in cycle 5
//  op=sw, MemReady low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, AdrSrc=1, then FETCH
//  op=beq: Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both take 3 cycles
//  op=7'b1111111 -> IllegalOp=1 for 1 cycle in DECODE, back to FETCH, InstrCount unchanged
//  CNT_W=4, retire 17 instructions -> InstrCount=1 (wrapped)
//  reset_n low during MEMWR -> MemWrite drops immediately (async), FETCH after release

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic             Zero;
   logic             MemReady;
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ImmSrc;
   logic [1:0]       ALUOp;
   logic             RegWrite;
   logic             IllegalOp;
   logic             Retire;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      input  op, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
      output ALUOp, RegWrite, IllegalOp, Retire,
      output InstrCount
   );

   modport slave (
      output op, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
      input  ALUOp, RegWrite, IllegalOp, Retire,
      input  InstrCount
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core.
// Sequences PC/ALU/memory, stalls on MemReady, counts retirements.
module multicycle_ctrl #(
   parameter int WAIT_MEM = 1,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR,
      EXECR, EXECI, ALUWB, BEQ, JAL
   } state_t;

   typedef struct packed {
      logic       fetch;
      logic       decode;
      logic       adr_src;
      logic       mem_wr;
      logic       reg_write;
      logic       retire;
      logic       branch;
      logic       pc_update;
      logic [1:0] res_src;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] alu_op;
   } ctl_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic NO_WAIT = (WAIT_MEM == 0);

   state_t           state;
   state_t           nxt;
   ctl_t             ctl_q;
   ctl_t             ctl_d;
   logic [CNT_W-1:0] cnt;
   logic             rdy;
   logic             fetch_go;
   logic             retire;
   logic             is_lw, is_sw, is_r;
   logic             is_i, is_beq, is_jal;
   logic             legal;
   logic [1:0]       imm_src;

   assign rdy    = bus.MemReady | NO_WAIT;
   assign is_lw  = (bus.op == OP_LW);
   assign is_sw  = (bus.op == OP_SW);
   assign is_r   = (bus.op == OP_R);
   assign is_i   = (bus.op == OP_I);
   assign is_beq = (bus.op == OP_BEQ);
   assign is_jal = (bus.op == OP_JAL);
   assign legal  = is_lw | is_sw | is_r
                 | is_i | is_beq | is_jal;

   always_comb begin
      nxt = state;
      unique case (state)
         FETCH:   nxt = rdy ? DECODE : FETCH;
         DECODE: begin
            unique case (1'b1)
               is_lw,
               is_sw:   nxt = MEMADR;
               is_r:    nxt = EXECR;
               is_i:    nxt = EXECI;
               is_beq:  nxt = BEQ;
               is_jal:  nxt = JAL;
               default: nxt = FETCH;
            endcase
         end
         MEMADR:  nxt = is_lw ? MEMREAD : MEMWR;
         MEMREAD: nxt = rdy ? MEMWB : MEMREAD;
         MEMWR:   nxt = rdy ? FETCH : MEMWR;
         EXECR:   nxt = ALUWB;
         EXECI:   nxt = ALUWB;
         JAL:     nxt = ALUWB;
         MEMWB:   nxt = FETCH;
         ALUWB:   nxt = FETCH;
         BEQ:     nxt = FETCH;
         default: nxt = FETCH;
      endcase
   end

   // Per-state controls are decoded from the next state and registered,
   // so they come straight off flops in the cycle the state is entered.
   function automatic ctl_t ctl_of(state_t s);
      ctl_t c;
      c = '0;
      unique case (s)
         FETCH: begin
            c.fetch   = 1'b1;
            c.src_b   = 2'b10;
            c.res_src = 2'b10;
         end
         DECODE: begin
            c.decode = 1'b1;
            c.src_a  = 2'b01;
            c.src_b  = 2'b01;
         end
         MEMADR: begin
            c.src_a = 2'b10;
            c.src_b = 2'b01;
         end
         MEMREAD: c.adr_src = 1'b1;
         MEMWB: begin
            c.res_src   = 2'b01;
            c.reg_write = 1'b1;
            c.retire    = 1'b1;
         end
         MEMWR: begin
            c.adr_src = 1'b1;
            c.mem_wr  = 1'b1;
         end
         EXECR: begin
            c.src_a  = 2'b10;
            c.alu_op = 2'b10;
         end
         EXECI: begin
            c.src_a  = 2'b10;
            c.src_b  = 2'b01;
            c.alu_op = 2'b10;
         end
         ALUWB: begin
            c.reg_write = 1'b1;
            c.retire    = 1'b1;
         end
         BEQ: begin
            c.src_a  = 2'b10;
            c.alu_op = 2'b01;
            c.branch = 1'b1;
            c.retire = 1'b1;
         end
         JAL: begin
            c.src_a     = 2'b01;
            c.src_b     = 2'b10;
            c.pc_update = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign ctl_d = ctl_of(nxt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
         ctl_q <= ctl_of(FETCH);
         cnt   <= '0;
      end else begin
         state <= nxt;
         ctl_q <= ctl_d;
         if (retire)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      imm_src = 2'b00;
      unique case (1'b1)
         is_sw:   imm_src = 2'b01;
         is_beq:  imm_src = 2'b10;
         is_jal:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // FETCH flags reset to 1, so the rdy-qualified strobes are also
   // gated by reset_n to stay quiet while reset is held.
   assign fetch_go = ctl_q.fetch & rdy & reset_n;
   assign retire   = ctl_q.retire | (ctl_q.mem_wr & rdy);

   assign bus.PCWrite    = fetch_go | ctl_q.pc_update
                         | (ctl_q.branch & bus.Zero);
   assign bus.IRWrite    = fetch_go;
   assign bus.AdrSrc     = ctl_q.adr_src;
   assign bus.MemWrite   = ctl_q.mem_wr;
   assign bus.ResultSrc  = ctl_q.res_src;
   assign bus.ALUSrcA    = ctl_q.src_a;
   assign bus.ALUSrcB    = ctl_q.src_b;
   assign bus.ALUOp      = ctl_q.alu_op;
   assign bus.ImmSrc     = imm_src;
   assign bus.RegWrite   = ctl_q.reg_write;
   assign bus.IllegalOp  = ctl_q.decode & ~legal;
   assign bus.Retire     = retire;
   assign bus.InstrCount = cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control
// vectors are queued with their stimulus and compared as they play out.
module tb_multicycle_ctrl;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQO = 7'b1100011;
   localparam logic [6:0] JLO = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   localparam int F = 0, D = 1, MA = 2, MR = 3;
   localparam int MWB = 4, MW = 5, XR = 6, XI = 7;
   localparam int AWB = 8, BQ = 9, JL = 10;

   typedef struct {
      logic [16:0] vec;
      logic [31:0] cnt;
      logic        rdy;
      logic        z;
      logic [6:0]  op;
      int          st;
   } item_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   item_t       q[$];
   logic [31:0] mcnt;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(32)) bus0 ();
   multicycle_ctrl_if #(.CNT_W(4))  bus1 ();

   multicycle_ctrl #(.WAIT_MEM(1), .CNT_W(32)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0.master)
   );

   multicycle_ctrl #(.WAIT_MEM(0), .CNT_W(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1.master)
   );

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic legal(logic [6:0] o);
      return (o == LW) || (o == SW) || (o == RT) ||
             (o == IT) || (o == BQO) || (o == JLO);
   endfunction

   function automatic logic [16:0] ev(int st, logic r,
                                      logic z, logic [6:0] o);
      logic pcw, adr, mw, irw, rw, ill, ret;
      logic [1:0] res, sa, sb, aop, imm;
      {pcw, adr, mw, irw, rw, ill, ret} = '0;
      {res, sa, sb, aop} = '0;
      case (st)
         F:   begin sb = 2; res = 2; irw = r; pcw = r; end
         D:   begin sa = 1; sb = 1; ill = !legal(o); end
         MA:  begin sa = 2; sb = 1; end
         MR:  adr = 1;
         MWB: begin res = 1; rw = 1; ret = 1; end
         MW:  begin adr = 1; mw = 1; ret = r; end
         XR:  begin sa = 2; aop = 2; end
         XI:  begin sa = 2; sb = 1; aop = 2; end
         AWB: begin rw = 1; ret = 1; end
         BQ:  begin sa = 2; aop = 1; pcw = z; ret = 1; end
         JL:  begin sa = 1; sb = 2; pcw = 1; end
         default: ;
      endcase
      case (o)
         SW:      imm = 2'b01;
         BQO:     imm = 2'b10;
         JLO:     imm = 2'b11;
         default: imm = 2'b00;
      endcase
      return {pcw, adr, mw, irw, res, sa, sb, aop,
              rw, ill, ret, imm};
   endfunction

   task automatic push(int st, logic r, logic z, logic [6:0] o);
      item_t it;
      it.vec = ev(st, r, z, o);
      it.cnt = mcnt;
      it.rdy = r;
      it.z   = z;
      it.op  = o;
      it.st  = st;
      q.push_back(it);
      if (it.vec[2]) mcnt = mcnt + 1;
   endtask

   task automatic plan(logic [6:0] o, logic z, int fw, int mwt);
      repeat (fw) push(F, 1'b0, rb(), BAD);
      push(F, 1'b1, rb(), BAD);
      push(D, rb(), rb(), o);
      case (o)
         LW: begin
            push(MA, rb(), rb(), o);
            repeat (mwt) push(MR, 1'b0, rb(), BAD);
            push(MR, 1'b1, rb(), BAD);
            push(MWB, rb(), rb(), BAD);
         end
         SW: begin
            push(MA, rb(), rb(), o);
            repeat (mwt) push(MW, 1'b0, rb(), BAD);
            push(MW, 1'b1, rb(), BAD);
         end
         RT: begin
            push(XR, rb(), rb(), BAD);
            push(AWB, rb(), rb(), BAD);
         end
         IT: begin
            push(XI, rb(), rb(), BAD);
            push(AWB, rb(), rb(), BAD);
         end
         BQO: push(BQ, rb(), z, BAD);
         JLO: begin
            push(JL, rb(), rb(), BAD);
            push(AWB, rb(), rb(), BAD);
         end
         default: ;
      endcase
   endtask

   // Entered and left at a negedge; n < 0 drains the whole queue.
   task automatic drain(int n);
      item_t it;
      logic [16:0] obs;
      int k = 0;
      while (q.size() > 0 && (n < 0 || k < n)) begin
         it = q.pop_front();
         bus0.MemReady = it.rdy;
         bus0.Zero     = it.z;
         bus0.op       = it.op;
         #1;
         obs = {bus0.PCWrite, bus0.AdrSrc, bus0.MemWrite,
                bus0.IRWrite, bus0.ResultSrc, bus0.ALUSrcA,
                bus0.ALUSrcB, bus0.ALUOp, bus0.RegWrite,
                bus0.IllegalOp, bus0.Retire, bus0.ImmSrc};
         total++;
         if (obs !== it.vec) begin
            bad++;
            $display("FAIL ctl st=%0d got=%b want=%b",
                     it.st, obs, it.vec);
         end
         total++;
         if (bus0.InstrCount !== it.cnt) begin
            bad++;
            $display("FAIL count st=%0d got=%0d want=%0d",
                     it.st, bus0.InstrCount, it.cnt);
         end
         @(negedge clk);
         k++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      q.delete();
      mcnt = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [5:0] s;
      reset_n = 1'b0;
      bus0.MemReady = 1'b1;
      bus0.Zero = 1'b1;
      bus0.op = BAD;
      repeat (3) @(negedge clk);
      #1;
      s = {bus0.PCWrite, bus0.IRWrite, bus0.MemWrite,
           bus0.RegWrite, bus0.IllegalOp, bus0.Retire};
      total++;
      if (s !== 6'b0) begin
         bad++;
         $display("FAIL reset_strobes got=%b want=0", s);
      end
      total++;
      if (bus0.InstrCount !== 32'd0) begin
         bad++;
         $display("FAIL reset_count got=%0d want=0",
                  bus0.InstrCount);
      end
      @(negedge clk);
      mcnt = 0;
      q.delete();
      reset_n = 1'b1;
   endtask

   task automatic test_lw();
      plan(LW, 1'b0, 0, 0);
      drain(-1);
   endtask

   task automatic test_sw_wait();
      plan(SW, 1'b0, 0, 3);
      drain(-1);
   endtask

   task automatic test_beq();
      plan(BQO, 1'b1, 0, 0);
      plan(BQO, 1'b0, 0, 0);
      drain(-1);
   endtask

   task automatic test_alu();
      plan(RT, 1'b0, 0, 0);
      plan(IT, 1'b0, 0, 0);
      plan(JLO, 1'b0, 0, 0);
      drain(-1);
   endtask

   task automatic test_illegal();
      plan(BAD, 1'b0, 0, 0);
      plan(7'b0000000, 1'b0, 0, 0);
      plan(RT, 1'b0, 0, 0);
      drain(-1);
   endtask

   task automatic test_waits();
      plan(LW, 1'b0, 2, 2);
      plan(SW, 1'b0, 1, 0);
      drain(-1);
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [7];
      ops = '{LW, SW, RT, IT, BQO, JLO, BAD};
      for (int i = 0; i < 14; i++)
         plan(ops[$urandom_range(0, 6)], rb(),
              $urandom_range(0, 1), $urandom_range(0, 2));
      drain(-1);
   endtask

   task automatic test_reset_mid();
      do_reset();
      plan(SW, 1'b0, 0, 6);
      drain(5);
      bus0.MemReady = 1'b0;
      #2;
      total++;
      if (bus0.MemWrite !== 1'b1) begin
         bad++;
         $display("FAIL mid_memwrite got=%b want=1", bus0.MemWrite);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (bus0.MemWrite !== 1'b0 || bus0.AdrSrc !== 1'b0) begin
         bad++;
         $display("FAIL async_drop mw=%b adr=%b want=0 0",
                  bus0.MemWrite, bus0.AdrSrc);
      end
      q.delete();
      mcnt = 0;
      @(negedge clk);
      reset_n = 1'b1;
      plan(RT, 1'b0, 0, 0);
      drain(-1);
   endtask

   task automatic test_wrap();
      logic [3:0] wq[$];
      logic [3:0] e;
      logic pend = 1'b0;
      int cyc = 0;
      bus1.MemReady = 1'b0;
      bus1.Zero = 1'b0;
      bus1.op = RT;
      do_reset();
      for (int k = 1; k <= 17; k++) wq.push_back(4'(k % 16));
      while (wq.size() > 0 && cyc < 100) begin
         #1;
         if (pend) begin
            e = wq.pop_front();
            total++;
            if (bus1.InstrCount !== e) begin
               bad++;
               $display("FAIL wrap_count got=%0d want=%0d",
                        bus1.InstrCount, e);
            end
            pend = 1'b0;
         end
         if (cyc % 4 == 0) begin
            total++;
            if (bus1.IRWrite !== 1'b1) begin
               bad++;
               $display("FAIL nowait_fetch cyc=%0d got=%b want=1",
                        cyc, bus1.IRWrite);
            end
         end
         if (bus1.Retire) pend = 1'b1;
         @(negedge clk);
         cyc++;
      end
      total++;
      if (wq.size() != 0 || cyc != 69) begin
         bad++;
         $display("FAIL wrap_timing left=%0d cyc=%0d want 0 69",
                  wq.size(), cyc);
      end
   endtask

   initial begin
      mcnt = 0;
      bus1.MemReady = 1'b0;
      bus1.Zero = 1'b0;
      bus1.op = RT;
      test_reset();
      test_lw();
      test_sw_wait();
      test_beq();
      test_alu();
      test_illegal();
      test_waits();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
